// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   - opcode constants recognised in the ID stage (MUL, JMP, HALT)
//   - FSM state encoding (RUN/MULT/FLUSH/HALT)
//   - default MUL latency and the width of the MUL stall counter
// Optional feature macro used by this block: PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

   localparam logic [3:0] OPC_MUL  = 4'hC;
   localparam logic [3:0] OPC_JMP  = 4'hA;
   localparam logic [3:0] OPC_HALT = 4'hF;

   // Legal MUL latency range is 1..7, so a 3-bit down-counter holds MUL_LAT-1.
   localparam int unsigned MUL_LAT_DEFAULT = 3;
   localparam int unsigned CNT_W           = 3;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StMult  = 2'd1,
      StFlush = 2'd2,
      StHalt  = 2'd3
   } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage / PC control bundle between the pipeline and pipe_ctrl.
//   master : pipeline side, drives id_valid, id_opcode, id_target, resume and
//            observes the control outputs.
//   slave  : controller side, drives stall, flush, pc_load, pc_target, ex_issue,
//            state, halted.
interface pipe_ctrl_if;

   logic       id_valid;
   logic [3:0] id_opcode;
   logic [7:0] id_target;
   logic       resume;
   logic       stall;
   logic       flush;
   logic       pc_load;
   logic [7:0] pc_target;
   logic       ex_issue;
   logic [1:0] state;
   logic       halted;

   modport master (
      output id_valid, id_opcode, id_target, resume,
      input  stall, flush, pc_load, pc_target, ex_issue, state, halted
   );

   modport slave (
      input  id_valid, id_opcode, id_target, resume,
      output stall, flush, pc_load, pc_target, ex_issue, state, halted
   );

endinterface

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: saturating 16-bit performance counters for pipe_ctrl.
// Present only in builds with PIPE_CTRL_PERF_EN defined.
//   clk, rst  : clock, asynchronous active-high reset (clears both counters)
//   cyc_en    : count this cycle in cyc_cnt (controller not halted)
//   stall_en  : count this cycle in stall_cnt (stall asserted)
//   cyc_cnt   : number of non-halted cycles, sticks at 16'hFFFF
//   stall_cnt : number of stalled cycles, sticks at 16'hFFFF
module pipe_ctrl_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        cyc_en,
   input  logic        stall_en,
   output logic [15:0] cyc_cnt,
   output logic [15:0] stall_cnt
);

   logic [15:0] cyc_q;
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q   <= 16'h0000;
         stall_q <= 16'h0000;
      end else begin
         if (cyc_en && (cyc_q != 16'hFFFF)) begin
            cyc_q <= cyc_q + 16'h0001;
         end
         if (stall_en && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
         end
      end
   end

   assign cyc_cnt   = cyc_q;
   assign stall_cnt = stall_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller for a simple in-order core.
// Handles multi-cycle MUL stalls, JMP redirect plus one-cycle IF/ID flush,
// and HALT with external resume.
//   MUL_LAT : MUL stall cycles, legal 1..7
//   clk     : clock, all state updates on the rising edge
//   rst     : asynchronous active-high reset; forces RUN and zeroes all outputs
//   bus     : pipe_ctrl_if.slave (ID inputs, resume, control outputs)
//   cyc_cnt, stall_cnt : perf counters, only when PIPE_CTRL_PERF_EN is defined
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [15:0] cyc_cnt,
   output logic [15:0] stall_cnt
`endif
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;

   logic       stall;
   logic       flush;
   logic       pc_load;
   logic [7:0] pc_target;
   logic       ex_issue;
   logic       halted;
   logic [1:0] state_dbg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            StRun: begin
               if (bus.id_valid) begin
                  if (bus.id_opcode == OPC_MUL) begin
                     cnt_q   <= CNT_W'(MUL_LAT - 1);
                     state_q <= StMult;
                  end else if (bus.id_opcode == OPC_JMP) begin
                     state_q <= StFlush;
                  end else if (bus.id_opcode == OPC_HALT) begin
                     state_q <= StHalt;
                  end
               end
            end
            StMult: begin
               // cnt==0 marks the last stall cycle.
               if (cnt_q == '0) begin
                  state_q <= StRun;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            StFlush: state_q <= StRun;
            StHalt: begin
               if (bus.resume) begin
                  state_q <= StRun;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   // Outputs decode straight from state and ID; rst masks them so a valid
   // instruction held in ID cannot leak ex_issue/pc_load during reset.
   always_comb begin
      stall     = 1'b0;
      flush     = 1'b0;
      pc_load   = 1'b0;
      pc_target = 8'h00;
      ex_issue  = 1'b0;
      halted    = 1'b0;
      state_dbg = 2'b00;
      if (!rst) begin
         state_dbg = state_q;
         case (state_q)
            StRun: begin
               if (bus.id_valid) begin
                  ex_issue = (bus.id_opcode != OPC_HALT);
                  if (bus.id_opcode == OPC_JMP) begin
                     pc_load   = 1'b1;
                     pc_target = bus.id_target;
                  end
               end
            end
            StMult:  stall = 1'b1;
            StFlush: flush = 1'b1;
            StHalt: begin
               stall  = 1'b1;
               halted = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.stall     = stall;
   assign bus.flush     = flush;
   assign bus.pc_load   = pc_load;
   assign bus.pc_target = pc_target;
   assign bus.ex_issue  = ex_issue;
   assign bus.halted    = halted;
   assign bus.state     = state_dbg;

`ifdef PIPE_CTRL_PERF_EN
   pipe_ctrl_perf u_perf (
      .clk       (clk),
      .rst       (rst),
      .cyc_en    (state_q != StHalt),
      .stall_en  (stall),
      .cyc_cnt   (cyc_cnt),
      .stall_cnt (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Two instances: u_dut3 (MUL_LAT=3) carries most scenarios, u_dut1 (MUL_LAT=1)
// checks the single-cycle MUL stall.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   pipe_ctrl_if b3 ();
   pipe_ctrl_if b1 ();

`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] cyc3, stl3, cyc1, stl1;
`endif

   pipe_ctrl #(.MUL_LAT(3)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (b3.slave)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .cyc_cnt   (cyc3),
      .stall_cnt (stl3)
`endif
   );

   pipe_ctrl #(.MUL_LAT(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .cyc_cnt   (cyc1),
      .stall_cnt (stl1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed outputs packed as {stall,flush,pc_load,ex_issue,halted,state,pc_target}.
   logic [14:0] obs3, obs1;
   assign obs3 = {b3.stall, b3.flush, b3.pc_load, b3.ex_issue, b3.halted, b3.state, b3.pc_target};
   assign obs1 = {b1.stall, b1.flush, b1.pc_load, b1.ex_issue, b1.halted, b1.state, b1.pc_target};

   function automatic logic [14:0] e(input logic s, input logic f, input logic l, input logic i,
                                     input logic h, input logic [1:0] st, input logic [7:0] t);
      return {s, f, l, i, h, st, t};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive3(input logic v, input logic [3:0] op, input logic [7:0] tgt);
      b3.id_valid  = v;
      b3.id_opcode = op;
      b3.id_target = tgt;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive3(1'b1, OPC_JMP, 8'h55);
      #1;
      n_cmp++;
      if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want %h", obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
      end
      step();
      drive3(1'b0, 4'h0, 8'h00);
      rst = 1'b0;
      step();
      n_cmp++;
      if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL idle_run: got %h want %h", obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
      end
   endtask

   task automatic test_plain_issue();
      drive3(1'b1, 4'h3, 8'h77);
      #1;
      n_cmp++;
      if (obs3 !== e(0, 0, 0, 1, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL plain_issue: got %h want %h", obs3, e(0, 0, 0, 1, 0, StRun, 8'h00));
      end
      step();
      n_cmp++;
      if (obs3 !== e(0, 0, 0, 1, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL plain_stays_run: got %h want %h", obs3, e(0, 0, 0, 1, 0, StRun, 8'h00));
      end
      drive3(1'b0, 4'h0, 8'h00);
      step();
   endtask

   task automatic test_mul();
      drive3(1'b1, OPC_MUL, 8'h00);
      #1;
      n_cmp++;
      if (obs3 !== e(0, 0, 0, 1, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL mul_issue: got %h want %h", obs3, e(0, 0, 0, 1, 0, StRun, 8'h00));
      end
      step();
      drive3(1'b0, 4'h0, 8'h00);
      for (int k = 1; k <= 3; k++) begin
         #1;
         n_cmp++;
         if (obs3 !== e(1, 0, 0, 0, 0, StMult, 8'h00)) begin
            n_fail++;
            $display("FAIL mul_stall T+%0d: got %h want %h", k, obs3, e(1, 0, 0, 0, 0, StMult, 8'h00));
         end
         step();
      end
      n_cmp++;
      if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL mul_done: got %h want %h", obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
      end
      // MUL_LAT=1 instance: exactly one stall cycle.
      b1.id_valid  = 1'b1;
      b1.id_opcode = OPC_MUL;
      #1;
      n_cmp++;
      if (obs1 !== e(0, 0, 0, 1, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL mul1_issue: got %h want %h", obs1, e(0, 0, 0, 1, 0, StRun, 8'h00));
      end
      step();
      b1.id_valid = 1'b0;
      #1;
      n_cmp++;
      if (obs1 !== e(1, 0, 0, 0, 0, StMult, 8'h00)) begin
         n_fail++;
         $display("FAIL mul1_stall: got %h want %h", obs1, e(1, 0, 0, 0, 0, StMult, 8'h00));
      end
      step();
      n_cmp++;
      if (obs1 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL mul1_done: got %h want %h", obs1, e(0, 0, 0, 0, 0, StRun, 8'h00));
      end
   endtask

   task automatic test_jmp();
      logic [3:0] in_flush [2];
      in_flush[0] = OPC_JMP;
      in_flush[1] = OPC_HALT;
      for (int k = 0; k < 2; k++) begin
         drive3(1'b1, OPC_JMP, 8'h20);
         #1;
         n_cmp++;
         if (obs3 !== e(0, 0, 1, 1, 0, StRun, 8'h20)) begin
            n_fail++;
            $display("FAIL jmp_load[%0d]: got %h want %h", k, obs3, e(0, 0, 1, 1, 0, StRun, 8'h20));
         end
         step();
         // Instruction in ID during FLUSH must be ignored.
         drive3(1'b1, in_flush[k], 8'h33);
         #1;
         n_cmp++;
         if (obs3 !== e(0, 1, 0, 0, 0, StFlush, 8'h00)) begin
            n_fail++;
            $display("FAIL jmp_flush[%0d]: got %h want %h", k, obs3, e(0, 1, 0, 0, 0, StFlush, 8'h00));
         end
         step();
         drive3(1'b0, 4'h0, 8'h00);
         #1;
         n_cmp++;
         if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
            n_fail++;
            $display("FAIL jmp_after[%0d]: got %h want %h", k, obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
         end
         step();
         n_cmp++;
         if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
            n_fail++;
            $display("FAIL jmp_not_taken[%0d]: got %h want %h", k, obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
         end
      end
   endtask

   task automatic test_halt();
      drive3(1'b1, OPC_HALT, 8'h00);
      #1;
      n_cmp++;
      if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL halt_no_issue: got %h want %h", obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
      end
      step();
      drive3(1'b0, 4'h0, 8'h00);
      b3.resume = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         n_cmp++;
         if (obs3 !== e(1, 0, 0, 0, 1, StHalt, 8'h00)) begin
            n_fail++;
            $display("FAIL halt_hold[%0d]: got %h want %h", k, obs3, e(1, 0, 0, 0, 1, StHalt, 8'h00));
         end
         step();
      end
      b3.resume = 1'b1;
      step();
      b3.resume = 1'b0;
      n_cmp++;
      if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL halt_resume: got %h want %h", obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
      end
      b3.resume = 1'b1;
      step();
      b3.resume = 1'b0;
      n_cmp++;
      if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
         n_fail++;
         $display("FAIL resume_in_run: got %h want %h", obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
      end
   endtask

   task automatic test_back_to_back();
      int issues;
      int loads;
      issues = 0;
      loads  = 0;
      drive3(1'b1, OPC_MUL, 8'h00);
      #1;
      issues += int'(b3.ex_issue);
      step();
      // JMP arrives in ID while MUL stalls; it is held until RUN.
      drive3(1'b1, OPC_JMP, 8'h44);
      for (int k = 0; k < 3; k++) begin
         #1;
         issues += int'(b3.ex_issue);
         loads  += int'(b3.pc_load);
         step();
      end
      n_cmp++;
      if (obs3 !== e(0, 0, 1, 1, 0, StRun, 8'h44)) begin
         n_fail++;
         $display("FAIL b2b_jmp: got %h want %h", obs3, e(0, 0, 1, 1, 0, StRun, 8'h44));
      end
      issues += int'(b3.ex_issue);
      loads  += int'(b3.pc_load);
      step();
      drive3(1'b0, 4'h0, 8'h00);
      #1;
      issues += int'(b3.ex_issue);
      n_cmp++;
      if (obs3 !== e(0, 1, 0, 0, 0, StFlush, 8'h00)) begin
         n_fail++;
         $display("FAIL b2b_flush: got %h want %h", obs3, e(0, 1, 0, 0, 0, StFlush, 8'h00));
      end
      step();
      n_cmp++;
      if ((issues !== 2) || (loads !== 1)) begin
         n_fail++;
         $display("FAIL b2b_counts: got issues=%0d loads=%0d want issues=2 loads=1", issues, loads);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] ops [3];
      logic [1:0] sts [3];
      ops[0] = OPC_MUL;  sts[0] = StMult;
      ops[1] = OPC_JMP;  sts[1] = StFlush;
      ops[2] = OPC_HALT; sts[2] = StHalt;
      for (int k = 0; k < 3; k++) begin
         drive3(1'b1, ops[k], 8'h10);
         step();
         drive3(1'b0, 4'h0, 8'h00);
         n_cmp++;
         if (b3.state !== sts[k]) begin
            n_fail++;
            $display("FAIL rstmid_enter[%0d]: got %0d want %0d", k, b3.state, sts[k]);
         end
         rst = 1'b1;
         #1;
         n_cmp++;
         if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
            n_fail++;
            $display("FAIL rstmid_async[%0d]: got %h want %h", k, obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
         end
         rst = 1'b0;
         #1;
         n_cmp++;
         if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
            n_fail++;
            $display("FAIL rstmid_release[%0d]: got %h want %h", k, obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
         end
         step();
         n_cmp++;
         if (obs3 !== e(0, 0, 0, 0, 0, StRun, 8'h00)) begin
            n_fail++;
            $display("FAIL rstmid_after[%0d]: got %h want %h", k, obs3, e(0, 0, 0, 0, 0, StRun, 8'h00));
         end
      end
   endtask

`ifdef PIPE_CTRL_PERF_EN
   task automatic test_perf();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      n_cmp++;
      if ((stl3 !== 16'd0) || (cyc3 !== 16'd0)) begin
         n_fail++;
         $display("FAIL perf_reset: got cyc=%0d stall=%0d want 0 0", cyc3, stl3);
      end
      for (int k = 0; k < 5; k++) begin
         drive3(1'b1, OPC_MUL, 8'h00);
         step();
         drive3(1'b0, 4'h0, 8'h00);
         for (int j = 0; j < 3; j++) step();
      end
      n_cmp++;
      if (stl3 !== 16'd15) begin
         n_fail++;
         $display("FAIL perf_stall_cnt: got %0d want 15", stl3);
      end
      for (int k = 0; k < 65540; k++) step();
      n_cmp++;
      if (cyc3 !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL perf_saturate: got %h want ffff", cyc3);
      end
   endtask
`endif

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      b3.id_valid = 1'b0; b3.id_opcode = 4'h0; b3.id_target = 8'h00; b3.resume = 1'b0;
      b1.id_valid = 1'b0; b1.id_opcode = 4'h0; b1.id_target = 8'h00; b1.resume = 1'b0;
      test_reset();
      test_plain_issue();
      test_mul();
      test_jmp();
      test_halt();
      test_back_to_back();
      test_reset_mid();
`ifdef PIPE_CTRL_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 3, SHALL set the stall cycles for a MUL instruction; legal range 1..7.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 id_valid  input  1  ID stage holds a valid instruction.
REQ-005 id_opcode  input  4  decoded opcode, instr[19:16].
REQ-006 id_target  input  8  jump target, decoded A field.
REQ-007 resume  input  1  leave HALT.
REQ-008 stall  output  1  hold PC and the IF/ID register.
REQ-009 flush  output  1  invalidate the IF/ID register contents.
REQ-010 pc_load  output  1  load PC with pc_target on the next edge.
REQ-011 pc_target  output  8  PC load value.
REQ-012 ex_issue  output  1  the ID instruction is passed to EX this cycle.
REQ-013 state  output  2  FSM state, for debug.
REQ-014 halted  output  1  high while the FSM is in HALT.

Function
REQ-015 The FSM SHALL have four states: RUN=0, MULT=1, FLUSH=2, HALT=3.
REQ-016 Outputs SHALL be combinational from the current state and ID inputs, with no extra register stage.
REQ-017 In RUN, ex_issue SHALL equal id_valid AND (id_opcode != HALT).
REQ-018 RUN with id_valid and opcode MUL (4'hC) SHALL load cnt=MUL_LAT-1 and move to MULT.
REQ-019 MULT SHALL drive stall=1 and ex_issue=0.
REQ-020 In MULT, cnt SHALL decrement each cycle; cnt==0 SHALL return the FSM to RUN on the next edge, giving exactly MUL_LAT stall cycles.
REQ-021 RUN with id_valid and opcode JMP (4'hA) SHALL, in the same cycle, drive pc_load=1 and pc_target=id_target, then move to FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle with flush=1, ex_issue=0, stall=0, and SHALL ignore ID contents, including MUL, JMP and HALT.
REQ-023 RUN with id_valid and opcode HALT (4'hF) SHALL move to HALT.
REQ-024 HALT SHALL drive stall=1 and halted=1; resume=1 SHALL return the FSM to RUN on the next edge.
REQ-025 resume SHALL be ignored outside HALT.
REQ-026 In RUN, id_valid=0 SHALL cause no transition and all outputs SHALL be 0.
REQ-027 Outside the JMP cycle, pc_load SHALL be 0 and pc_target SHALL be 0.
REQ-028 Unlisted opcodes SHALL issue with no stall.

Reset
REQ-029 rst SHALL asynchronously force state=RUN and cnt=0.
REQ-030 While rst is high, all outputs SHALL be 0.
REQ-031 rst asserted mid-MULT, mid-FLUSH or mid-HALT SHALL abort the operation immediately, with no pending stall or flush afterwards.

Configuration
REQ-032 With PIPE_CTRL_PERF_EN defined, the block SHALL add outputs cyc_cnt[15:0], counting every cycle not in HALT, and stall_cnt[15:0], counting cycles with stall=1.
REQ-033 Both counters SHALL saturate at 16'hFFFF and SHALL reset to 0 on rst.
REQ-034 With PIPE_CTRL_PERF_EN undefined, these ports and their logic SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-035 Package pipe_ctrl_pkg SHALL hold the opcode constants (OPC_MUL, OPC_JMP, OPC_HALT), the state encoding, and the MUL_LAT default.
REQ-036 Sub-module pipe_ctrl_perf SHALL implement the saturating counters and SHALL be instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-037 Reset mid-MULT: rst pulse while in MULT -> state=RUN and stall=0 asynchronously; no stall after release.
REQ-038 MUL with MUL_LAT=3: MUL valid at cycle T -> ex_issue=1 at T, stall=1 at T+1..T+3, RUN at T+4; with MUL_LAT=1 -> one stall cycle.
REQ-039 JMP with id_target=8'h20: pc_load=1 and pc_target=8'h20 at T, flush=1 at T+1, RUN at T+2; a JMP present in ID during FLUSH is not taken.
REQ-040 HALT: halted=1 and stall=1 hold for 10 cycles with resume=0; resume=1 at cycle N -> RUN at N+1; resume=1 in RUN has no effect.
REQ-041 Back-to-back: MUL followed immediately by JMP -> JMP issues in the first RUN cycle after the stall, with no lost or duplicated issue.
REQ-042 PERF_EN: 5 MUL instructions with MUL_LAT=3 -> stall_cnt=15; forced counter near 16'hFFFF -> saturates at 16'hFFFF.
